// File: rtl/branch_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_fetch_sequencer_if
//  Description : Bundle between the fetch stage and the branch fetch
//                sequencer.
//                  ir_f, ir_f_valid - instruction currently in fetch
//                  ex_valid         - held branch is in EX this cycle
//                  br_taken         - EX comparator result
//                  pipe_stall       - global stall, freezes the sequencer
//                  pc               - fetch address (registered)
//                  fetch_hold       - fetch must not advance (bubble)
//                  flush_f          - clear IF/ID this cycle
//                  branch_busy      - branch awaiting resolution
//                  taken_cnt        - saturating taken-branch count
//                  wd_err           - sticky watchdog-expired flag
//                Modports: slave = sequencer side, master = pipeline side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_fetch_sequencer_if;
    logic [31:0] ir_f;
    logic        ir_f_valid;
    logic        ex_valid;
    logic        br_taken;
    logic        pipe_stall;
    logic [31:0] pc;
    logic        fetch_hold;
    logic        flush_f;
    logic        branch_busy;
    logic [15:0] taken_cnt;
    logic        wd_err;

    modport slave (
        input  ir_f, ir_f_valid, ex_valid, br_taken, pipe_stall,
        output pc, fetch_hold, flush_f, branch_busy, taken_cnt, wd_err
    );

    modport master (
        output ir_f, ir_f_valid, ex_valid, br_taken, pipe_stall,
        input  pc, fetch_hold, flush_f, branch_busy, taken_cnt, wd_err
    );
endinterface
`default_nettype wire

// File: rtl/branch_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_fetch_sequencer
//  Description : Owns the fetch PC. A fetched conditional branch (opcodes
//                0x04..0x07) parks fetch at the fall-through address until
//                the EX comparator resolves it, then redirects the PC and
//                flushes IF/ID for one cycle. A watchdog forces not-taken if
//                resolution never arrives. No delay slots.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous, active-high
//                bus   - branch_fetch_sequencer_if.slave
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 15
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    branch_fetch_sequencer_if.slave       bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_REDIRECT = 2'd2;

    // wait_cnt value on which the watchdog fires (WAIT_LIMIT cycles in WAIT)
    localparam logic [7:0] c_WAIT_LAST = 8'(WAIT_LIMIT - 1);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_taken_cnt;
    logic        r_wd_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_offset;
    logic        w_is_branch;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_offset    = {{14{bus.ir_f[15]}}, bus.ir_f[15:0], 2'b00};
    // opcodes 000100..000111 share the upper four bits 0001
    assign w_is_branch = (bus.ir_f[31:28] == 4'b0001);

    // register fields of the branch are irrelevant to sequencing
    logic w_unused;
    assign w_unused = &{1'b0, bus.ir_f[25:16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_pc        <= RESET_PC;
            r_target    <= 32'd0;
            r_wait_cnt  <= 8'd0;
            r_taken_cnt <= 16'd0;
            r_wd_err    <= 1'b0;
        end else if (!bus.pipe_stall) begin
            case (r_state)
                c_IDLE: begin
                    if (bus.ir_f_valid) begin
                        r_pc <= w_pc_plus4;
                        if (w_is_branch) begin
                            r_target   <= w_pc_plus4 + w_offset;
                            r_wait_cnt <= 8'd0;
                            r_state    <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    // ex_valid has priority over a coincident watchdog expiry
                    if (bus.ex_valid) begin
                        if (bus.br_taken) begin
                            r_pc <= r_target;
                            if (r_taken_cnt != 16'hFFFF)
                                r_taken_cnt <= r_taken_cnt + 16'd1;
                        end
                        r_state <= c_REDIRECT;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        // pc already holds the fall-through: not-taken
                        r_wd_err <= 1'b1;
                        r_state  <= c_REDIRECT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                c_REDIRECT: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.fetch_hold  = (r_state != c_IDLE);
    assign bus.flush_f     = (r_state == c_REDIRECT);
    assign bus.branch_busy = (r_state == c_WAIT);
    assign bus.taken_cnt   = r_taken_cnt;
    assign bus.wd_err      = r_wd_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_fetch_sequencer
//  Description : Directed self-checking bench for branch_fetch_sequencer
//                (RESET_PC = 0, WAIT_LIMIT = 15).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_fetch_sequencer;

    localparam logic [31:0] c_ALU = 32'h2000_0000;   // addi, not a branch

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    branch_fetch_sequencer_if bif ();

    branch_fetch_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .WAIT_LIMIT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] br(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic fetch(input logic [31:0] ir);
        bif.ir_f       = ir;
        bif.ir_f_valid = 1'b1;
        tick;
        bif.ir_f_valid = 1'b0;
    endtask

    task automatic resolve(input logic taken);
        bif.ex_valid = 1'b1;
        bif.br_taken = taken;
        tick;
        bif.ex_valid = 1'b0;
        bif.br_taken = 1'b0;
    endtask

    initial begin
        bif.ir_f = 32'd0; bif.ir_f_valid = 1'b0; bif.ex_valid = 1'b0;
        bif.br_taken = 1'b0; bif.pipe_stall = 1'b0;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;

        // reset state
        check_eq("rst_pc",   bif.pc, 32'h0);
        check_eq("rst_hold", {31'd0, bif.fetch_hold}, 32'd0);
        check_eq("rst_flush",{31'd0, bif.flush_f}, 32'd0);
        check_eq("rst_busy", {31'd0, bif.branch_busy}, 32'd0);
        check_eq("rst_cnt",  {16'd0, bif.taken_cnt}, 32'd0);
        check_eq("rst_wd",   {31'd0, bif.wd_err}, 32'd0);

        // straight-line code
        for (int i = 1; i <= 4; i++) begin
            fetch(c_ALU);
            check_eq("seq_pc",   bif.pc, 32'(i * 4));
            check_eq("seq_hold", {31'd0, bif.fetch_hold}, 32'd0);
        end
        tick;                                   // ir_f_valid=0: pc holds
        check_eq("idle_hold_pc", bif.pc, 32'h10);

        // walk to 0x100
        for (int i = 0; i < 60; i++) fetch(c_ALU);
        check_eq("walk_pc", bif.pc, 32'h100);

        // taken BEQ at 0x100, imm 3: target = 0x104 + 0xC = 0x110
        fetch(br(6'h04, 16'h0003));
        check_eq("beq_fall",  bif.pc, 32'h104);
        check_eq("beq_busy",  {31'd0, bif.branch_busy}, 32'd1);
        check_eq("beq_hold",  {31'd0, bif.fetch_hold}, 32'd1);
        fetch(br(6'h05, 16'h7777));             // ignored while waiting
        check_eq("beq_wait_pc", bif.pc, 32'h104);
        resolve(1'b1);
        check_eq("beq_tgt",   bif.pc, 32'h110);
        check_eq("beq_flush", {31'd0, bif.flush_f}, 32'd1);
        check_eq("beq_cnt",   {16'd0, bif.taken_cnt}, 32'd1);
        check_eq("beq_busy2", {31'd0, bif.branch_busy}, 32'd0);
        fetch(c_ALU);                           // ignored in REDIRECT
        check_eq("beq_redir_pc", bif.pc, 32'h110);
        check_eq("beq_flush2", {31'd0, bif.flush_f}, 32'd0);
        check_eq("beq_hold2",  {31'd0, bif.fetch_hold}, 32'd0);
        fetch(c_ALU);
        check_eq("beq_next",  bif.pc, 32'h114);

        // not-taken backward BNE at 0x200
        for (int i = 0; i < 59; i++) fetch(c_ALU);
        check_eq("walk2_pc", bif.pc, 32'h200);
        fetch(br(6'h05, 16'hFFFF));
        check_eq("bne_fall",  bif.pc, 32'h204);
        resolve(1'b0);
        check_eq("bne_pc",    bif.pc, 32'h204);
        check_eq("bne_flush", {31'd0, bif.flush_f}, 32'd1);
        check_eq("bne_cnt",   {16'd0, bif.taken_cnt}, 32'd1);
        tick;
        check_eq("bne_idle",  {31'd0, bif.flush_f}, 32'd0);
        check_eq("bne_pc2",   bif.pc, 32'h204);

        // stalls in WAIT and REDIRECT; BLEZ imm 0x10: target 0x208+0x40=0x248
        fetch(br(6'h06, 16'h0010));
        check_eq("stl_fall", bif.pc, 32'h208);
        bif.pipe_stall = 1'b1;
        bif.ex_valid = 1'b1; bif.br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_eq("stl_w_pc",   bif.pc, 32'h208);
            check_eq("stl_w_busy", {31'd0, bif.branch_busy}, 32'd1);
            check_eq("stl_w_cnt",  {16'd0, bif.taken_cnt}, 32'd1);
        end
        bif.pipe_stall = 1'b0;
        resolve(1'b1);
        check_eq("stl_tgt", bif.pc, 32'h248);
        check_eq("stl_cnt", {16'd0, bif.taken_cnt}, 32'd2);
        bif.pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(c_ALU);
            check_eq("stl_r_flush", {31'd0, bif.flush_f}, 32'd1);
            check_eq("stl_r_hold",  {31'd0, bif.fetch_hold}, 32'd1);
            check_eq("stl_r_pc",    bif.pc, 32'h248);
        end
        bif.pipe_stall = 1'b0;
        tick;
        check_eq("stl_done", {31'd0, bif.flush_f}, 32'd0);

        // watchdog: BGTZ at 0x248, no ex_valid
        fetch(br(6'h07, 16'h0001));
        check_eq("wd_fall", bif.pc, 32'h24C);
        for (int i = 1; i <= 14; i++) tick;
        check_eq("wd_still_busy", {31'd0, bif.branch_busy}, 32'd1);
        check_eq("wd_not_yet",    {31'd0, bif.wd_err}, 32'd0);
        tick;                                   // 15th cycle after WAIT entry
        check_eq("wd_flush", {31'd0, bif.flush_f}, 32'd1);
        check_eq("wd_err",   {31'd0, bif.wd_err}, 32'd1);
        check_eq("wd_pc",    bif.pc, 32'h24C);
        tick;
        fetch(br(6'h04, 16'h0000));
        resolve(1'b1);
        check_eq("wd_nb_pc",  bif.pc, 32'h250);
        check_eq("wd_sticky", {31'd0, bif.wd_err}, 32'd1);
        tick;

        // reset during WAIT
        fetch(br(6'h04, 16'h0004));
        check_eq("rw_busy", {31'd0, bif.branch_busy}, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_eq("rw_pc",   bif.pc, 32'h0);
        check_eq("rw_busy2",{31'd0, bif.branch_busy}, 32'd0);
        check_eq("rw_wd",   {31'd0, bif.wd_err}, 32'd0);
        check_eq("rw_cnt",  {16'd0, bif.taken_cnt}, 32'd0);

        // ex_valid on the watchdog's last cycle wins: BEQ at 0 imm 2 -> 0xC
        fetch(br(6'h04, 16'h0002));
        for (int i = 0; i < 14; i++) tick;
        resolve(1'b1);
        check_eq("co_pc", bif.pc, 32'hC);
        check_eq("co_wd", {31'd0, bif.wd_err}, 32'd0);
        tick;

        // backward wrap below 0 and pc+4 wrap: BEQ at 0xC imm 0xFFFC
        // target = 0x10 - 0x10 = 0; then BEQ at 0 imm 0xFFFE -> 4 - 8
        fetch(br(6'h04, 16'hFFFC));
        resolve(1'b1);
        check_eq("bk_pc", bif.pc, 32'h0);
        tick;
        fetch(br(6'h04, 16'hFFFE));
        resolve(1'b1);
        check_eq("wrap_tgt", bif.pc, 32'hFFFF_FFFC);
        tick;
        fetch(c_ALU);
        check_eq("wrap_pc", bif.pc, 32'h0);

        // saturation: preload counter just below the top
        force dut.r_taken_cnt = 16'hFFFE;
        #1;
        release dut.r_taken_cnt;
        #1;
        check_eq("sat_pre", {16'd0, bif.taken_cnt}, 32'h0000_FFFE);
        for (int i = 0; i < 2; i++) begin
            fetch(br(6'h04, 16'h0000));
            resolve(1'b1);
            check_eq("sat_cnt", {16'd0, bif.taken_cnt}, 32'h0000_FFFF);
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
